mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single multicycle data memory behind the LW/SW path between two requesters.
//   - I-side requester: instruction-cache miss.
//   - D-side requester: data-cache miss or SW write-through.
//  Each transaction is either a single-word write or a full cache-block fill (BLOCK_WORDS reads).
//  Sits between the cache controllers and the memory model; the pipeline stalls on cache busy.
// PARAMETERS
//  ADDR_W       16  byte address width
//  DATA_W       16  word width (one word = 2 bytes)
//  BLOCK_WORDS  8   words per fill, power of 2, >=2
//  MEM_LAT      4   memory read latency (en -> rvalid); bench model only, arbiter does not count it
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  i_req        in   1       I-side request, held high until i_done
//  i_we         in   1       1=write word, 0=block fill
//  i_addr       in   ADDR_W  byte address
//  i_wdata      in   DATA_W  write data
//  i_fill_valid out  1       fill word valid this cycle (I-side)
//  i_fill_idx   out  log2(BLOCK_WORDS)  word index of fill word
//  i_done       out  1       one-cycle pulse, I transaction complete
//  d_req/d_we/d_addr/d_wdata/d_fill_valid/d_fill_idx/d_done  same as I-side, for D-side
//  fill_data    out  DATA_W  fill word, shared by both sides
//  mem_en       out  1       memory access strobe
//  mem_wr       out  1       1=write, 0=read
//  mem_addr     out  ADDR_W  memory byte address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data
//  mem_rvalid   in   1       read data valid; pipelined, one per issued read, in order
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all outputs 0, counters 0, last_owner=I.
//  States: IDLE, WRITE, FILL, HOLD.
//  IDLE:
//   - Samples req. Only one req: grant it. Both: grant the side != last_owner.
//   - Latches owner, we, addr, wdata; updates last_owner.
//   - Next state WRITE if we, else FILL. No req: stay IDLE.
//  WRITE (1 cycle):
//   - mem_en=1, mem_wr=1, mem_addr=latched addr, mem_wdata=latched wdata.
//   - owner done=1 in the same cycle. Next state HOLD.
//  FILL:
//   - base = addr with low log2(BLOCK_WORDS)+1 bits cleared.
//   - Issue counter: mem_en=1, mem_wr=0, mem_addr=base+2*iss for iss=0..BLOCK_WORDS-1, one per cycle, no gaps.
//   - Return counter ret counts mem_rvalid.
//   - fill_data=mem_rdata; owner fill_valid=mem_rvalid; fill_idx=ret. All combinational, 0 latency.
//   - Return of word BLOCK_WORDS-1: owner done=1 same cycle; next state HOLD.
//  HOLD (1 cycle): no grant, all strobes 0; next IDLE. Requester must drop req before the following IDLE.
//  Latency, req seen in IDLE at cycle 0:
//   - First mem_en at cycle 1.
//   - Write: done at cycle 1.
//   - Fill: done at cycle BLOCK_WORDS+MEM_LAT.
//  Idle values: mem_en, mem_wr and all fill_valid/done are 0 outside WRITE/FILL; non-owner outputs always 0.
//  mem_rvalid outside FILL is ignored, including stale returns after reset. rvalid beyond BLOCK_WORDS is never counted.
//  Address arithmetic is modulo 2^ADDR_W; block bases never wrap inside a block.
//  req changes while granted are ignored; addr/we/wdata are used only from the latched copy.
// TESTING
//  1 Reset mid-idle, rst=0 for 2 cycles -> all outputs 0, last_owner=I.
//  2 D write, addr=0x0010, wdata=0xBEEF -> next cycle mem_en=1, mem_wr=1, mem_addr=0x0010,
//    mem_wdata=0xBEEF, d_done=1. HOLD, then IDLE.
//  3 I fill, addr=0x0036, MEM_LAT=4 -> mem_addr 0x0030..0x003E, 8 consecutive cycles.
//    i_fill_valid 8x, idx 0..7, data matches model; i_done with idx 7 at cycle 12.
//  4 i_req and d_req rise together after reset -> D granted first, then I after HOLD.
//    Both held high continuously -> grants alternate D,I,D,I.
//  5 rst=0 after 3 fill words returned -> outputs 0 immediately.
//    Late mem_rvalid ignored; next D fill at 0x0100 completes normally with idx 0..7.
//  6 D fill with memory model holding 0x1000+i at word i -> fill_data sequence 0x1000..0x1007.
//    i_fill_valid/i_done stay 0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the shared multicycle data memory.
// Grants either a single-word write or a BLOCK_WORDS burst fill; fill data is passed straight through.
module mem_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int BLOCK_WORDS = 8,
   parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              i_fill_valid,
   output logic [IDX_W-1:0]  i_fill_idx,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_fill_valid,
   output logic [IDX_W-1:0]  d_fill_idx,
   output logic              d_done,
   output logic [DATA_W-1:0] fill_data,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid
);

   // state | meaning
   // IDLE  | sample requests, grant one, latch its command
   // WRITE | one-cycle memory write, owner done
   // FILL  | issue BLOCK_WORDS reads, forward returns, done on last return
   // HOLD  | one dead cycle so the finished requester can drop req
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_HOLD} state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

   state_t              state_q, state_d;
   logic                owner_q;     // doubles as last_owner for the round-robin tie-break
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [IDX_W:0]      iss_q;
   logic [IDX_W-1:0]    ret_q;
   logic                grant_v, grant_d, sel_we;
   logic                done, fill_v;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         owner_q <= OWN_I;
         addr_q  <= '0;
         wdata_q <= '0;
         iss_q   <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         if (grant_v) begin
            owner_q <= grant_d;
            addr_q  <= grant_d ? d_addr : i_addr;
            wdata_q <= grant_d ? d_wdata : i_wdata;
            iss_q   <= '0;
            ret_q   <= '0;
         end else if (state_q == S_FILL) begin
            if (!iss_q[IDX_W]) iss_q <= iss_q + 1'b1;
            if (mem_rvalid)    ret_q <= ret_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_v   = 1'b0;
      grant_d   = 1'b0;
      sel_we    = 1'b0;
      done      = 1'b0;
      fill_v    = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fill_data = '0;
      case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               grant_v = 1'b1;
               grant_d = d_req && (!i_req || owner_q == OWN_I);
               sel_we  = grant_d ? d_we : i_we;
               state_d = sel_we ? S_WRITE : S_FILL;
            end
         end
         S_WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            done      = 1'b1;
            state_d   = S_HOLD;
         end
         S_FILL: begin
            if (!iss_q[IDX_W]) begin
               mem_en   = 1'b1;
               mem_addr = {addr_q[ADDR_W-1:IDX_W+1], iss_q[IDX_W-1:0], 1'b0};
            end
            fill_data = mem_rdata;
            fill_v    = mem_rvalid;
            if (mem_rvalid && ret_q == LAST_IDX) begin
               done    = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      i_fill_valid = 1'b0;
      d_fill_valid = 1'b0;
      i_fill_idx   = '0;
      d_fill_idx   = '0;
      i_done       = 1'b0;
      d_done       = 1'b0;
      if (owner_q == OWN_D) begin
         d_fill_valid = fill_v;
         d_done       = done;
         if (state_q == S_FILL) d_fill_idx = ret_q;
      end else begin
         i_fill_valid = fill_v;
         i_done       = done;
         if (state_q == S_FILL) i_fill_idx = ret_q;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: pipelined memory model, scoreboard queues,
// a vector table of single transactions and hand-written reset/arbitration sequences.
module tb_mem_arbiter;
   localparam int MEM_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_we, d_req, d_we;
   logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
   logic        i_fill_valid, i_done, d_fill_valid, d_done;
   logic [2:0]  i_fill_idx, d_fill_idx;
   logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
   logic        mem_en, mem_wr, mem_rvalid;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_fill_valid(i_fill_valid), .i_fill_idx(i_fill_idx), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_fill_valid(d_fill_valid), .d_fill_idx(d_fill_idx), .d_done(d_done),
      .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   // memory model: word at byte address a reads as seed ^ (a >> 1), MEM_LAT cycles after en
   logic [15:0]        seed = 16'h5A00;
   logic [MEM_LAT-1:0] pv_q = '0;
   logic [15:0]        pa_q [MEM_LAT];
   always @(posedge clk) begin
      pv_q     <= {pv_q[MEM_LAT-2:0], mem_en & ~mem_wr};
      pa_q[0]  <= mem_addr;
      for (int k = 1; k < MEM_LAT; k++) pa_q[k] <= pa_q[k-1];
   end
   assign mem_rvalid = pv_q[MEM_LAT-1];
   assign mem_rdata  = pv_q[MEM_LAT-1] ? (seed ^ {1'b0, pa_q[MEM_LAT-1][15:1]}) : 16'h0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   wire [59:0] outs = {i_fill_valid, i_fill_idx, i_done, d_fill_valid, d_fill_idx, d_done,
                       fill_data, mem_en, mem_wr, mem_addr, mem_wdata};

   typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
   typedef struct { logic side; logic wr; logic [2:0] idx; logic [15:0] data; } out_exp_t;
   mem_exp_t exp_mem [$];
   out_exp_t exp_out [$];
   mem_exp_t mon_em;
   out_exp_t mon_eo;
   logic [15:0] cap_data [8];
   int i_act_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (mem_en) begin
            if (exp_mem.size() == 0) check("mem_unexpected", {mem_wr, mem_addr}, 0);
            else begin
               mon_em = exp_mem.pop_front();
               check("mem_txn", {mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0},
                     {mon_em.wr, mon_em.addr, mon_em.wdata});
            end
         end
         if (i_fill_valid | i_done) i_act_cnt++;
         if (i_fill_valid | d_fill_valid) cap_data[i_fill_valid ? i_fill_idx : d_fill_idx] = fill_data;
         if (i_fill_valid | i_done | d_fill_valid | d_done) begin
            if (exp_out.size() == 0)
               check("out_unexpected", {i_fill_valid, i_done, d_fill_valid, d_done}, 0);
            else begin
               mon_eo = exp_out.pop_front();
               check("fill_out",
                     {i_fill_valid, i_fill_valid ? i_fill_idx : 3'd0, i_done,
                      d_fill_valid, d_fill_valid ? d_fill_idx : 3'd0, d_done,
                      (i_fill_valid | d_fill_valid) ? fill_data : 16'h0},
                     {(!mon_eo.side && !mon_eo.wr), mon_eo.wr ? 3'd0 : (mon_eo.side ? 3'd0 : mon_eo.idx),
                      (!mon_eo.side && (mon_eo.wr || mon_eo.idx == 3'd7)),
                      (mon_eo.side && !mon_eo.wr), mon_eo.wr ? 3'd0 : (mon_eo.side ? mon_eo.idx : 3'd0),
                      (mon_eo.side && (mon_eo.wr || mon_eo.idx == 3'd7)),
                      mon_eo.wr ? 16'h0 : mon_eo.data});
            end
         end
      end
   end

   task automatic push_exp(input logic side, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata);
      logic [15:0] a;
      if (we) begin
         exp_mem.push_back('{1'b1, addr, wdata});
         exp_out.push_back('{side, 1'b1, 3'd0, 16'h0});
      end else begin
         for (int i = 0; i < 8; i++) begin
            a = {addr[15:4], 4'h0} + 16'(2 * i);
            exp_mem.push_back('{1'b0, a, 16'h0});
            exp_out.push_back('{side, 1'b0, 3'(i), seed ^ {1'b0, a[15:1]}});
         end
      end
   endtask

   // called in an IDLE cycle just after a rising edge; returns in the next IDLE cycle
   task automatic run_txn(input logic side, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat, input string name);
      int  start;
      bit  got = 0;
      push_exp(side, we, addr, wdata);
      if (side) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
      else      begin i_req = 1; i_we = we; i_addr = addr; i_wdata = wdata; end
      start = cyc;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (side ? d_done : i_done) begin got = 1; break; end
      end
      check({name, "_done_seen"}, 64'(got), 64'd1);
      if (got) check({name, "_latency"}, 64'(cyc - start), 64'(lat));
      @(posedge clk); #1;
      i_req = 0; d_req = 0;
      check({name, "_hold_quiet"}, 64'(outs), 64'd0);
      @(posedge clk); #1;
   endtask

   typedef struct { logic side; logic we; logic [15:0] addr; logic [15:0] wdata; int lat; } vec_t;
   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_side [4];
      int   nd, n3;
      vecs[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1};
      vecs[1] = '{1'b0, 1'b0, 16'h0036, 16'h0000, 12};
      vecs[2] = '{1'b0, 1'b1, 16'hFFFE, 16'h1234, 1};
      vecs[3] = '{1'b1, 1'b0, 16'hFFF2, 16'h0000, 12};
      vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 12};
      vecs[5] = '{1'b1, 1'b1, 16'h0001, 16'h00FF, 1};
      exp_side[0] = 1'b1; exp_side[1] = 1'b0; exp_side[2] = 1'b1; exp_side[3] = 1'b0;

      rst = 0; i_req = 0; i_we = 0; i_addr = 0; i_wdata = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      repeat (2) @(posedge clk);
      #1 check("reset_outputs", 64'(outs), 64'd0);
      @(posedge clk); #1 rst = 1;

      foreach (vecs[v]) run_txn(vecs[v].side, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                                vecs[v].lat, $sformatf("vec%0d", v));

      // reset while idle; last grant was D, so reset must restore last_owner=I
      rst = 0;
      #1 check("idle_reset_outputs", 64'(outs), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1;

      // simultaneous requests held high: D first, then alternation
      push_exp(1'b1, 1'b1, 16'h0200, 16'h2222);
      push_exp(1'b0, 1'b1, 16'h0100, 16'h1111);
      push_exp(1'b1, 1'b1, 16'h0200, 16'h2222);
      push_exp(1'b0, 1'b1, 16'h0100, 16'h1111);
      i_we = 1; i_addr = 16'h0100; i_wdata = 16'h1111;
      d_we = 1; d_addr = 16'h0200; d_wdata = 16'h2222;
      i_req = 1; d_req = 1;
      nd = 0;
      for (int c = 0; c < 40 && nd < 4; c++) begin
         @(negedge clk);
         if (i_done | d_done) begin
            check($sformatf("grant_order%0d", nd), {i_done, d_done}, {!exp_side[nd], exp_side[nd]});
            nd++;
         end
      end
      check("grant_count", 64'(nd), 64'd4);
      @(posedge clk); #1 i_req = 0; d_req = 0;
      @(posedge clk); #1;

      // reset in the middle of an I fill after three returned words
      push_exp(1'b0, 1'b0, 16'h0040, 16'h0);
      i_we = 0; i_addr = 16'h0040; i_req = 1;
      n3 = 0;
      for (int c = 0; c < 30 && n3 < 3; c++) begin
         @(negedge clk);
         if (i_fill_valid) n3++;
      end
      check("mid_fill_words", 64'(n3), 64'd3);
      #2 rst = 0; i_req = 0;
      exp_mem.delete(); exp_out.delete();
      #1 check("mid_fill_reset_outputs", 64'(outs), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      check("stale_rvalid_ignored", 64'(outs), 64'd0);
      run_txn(1'b1, 1'b0, 16'h0100, 16'h0, 12, "post_reset_fill");

      // D fill with known contents; I side must stay silent
      seed = 16'h1100;
      foreach (cap_data[k]) cap_data[k] = 16'h0;
      n3 = i_act_cnt;
      run_txn(1'b1, 1'b0, 16'h0200, 16'h0, 12, "d_fill_pattern");
      for (int k = 0; k < 8; k++) check($sformatf("pattern_word%0d", k), 64'(cap_data[k]), 64'(16'h1000 + k));
      check("i_side_silent", 64'(i_act_cnt - n3), 64'd0);
      check("scoreboard_drained", 64'(exp_mem.size() + exp_out.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
